detect_sequencer: RTL
=====================

# detect_sequencer

Run-time sequencer for one detection burst cycle: transmit, blanking, receive window, rest, repeat. It sits between the debounced key pulse and the transmitter/receiver datapaths, and replaces ad-hoc enTx control. It owns all phase timing, the transmitter timeout and echo hit/miss reporting.

## Interface
- GUARD_CYC, default 1000: blanking cycles between end of TX and start of RX (≥1)
- RX_CYC, default 200000: receive window length in cycles (≥1)
- REST_CYC, default 1000000: idle cycles between bursts (≥1)
- TX_TIMEOUT, default 100000: maximum TX cycles waiting for overTx (≥1)
- CNT_W, default 24: phase counter width; every cycle parameter must be < 2^CNT_W

Ports:
- clk_100  in  1  system clock, 100 MHz
- rst  in  1  reset; synchronous, active-high
- run_tgl  in  1  one-cycle pulse from key debounce; toggles run/stop
- overTx  in  1  transmitter done; sampled only in TX
- rx_done  in  1  receiver echo captured; sampled only in RX
- enTx  out  1  transmitter enable
- enRx  out  1  receiver window enable
- busy  out  1  FSM not in IDLE
- running  out  1  run flag
- rx_hit  out  1  one-cycle pulse: echo inside window
- rx_miss  out  1  one-cycle pulse: window expired without echo
- err_tx  out  1  sticky TX timeout flag
- burst_cnt  out  16  completed RX phases, wraps 0xFFFF→0

## Operation
- States: IDLE, TX, GUARD, RX, REST; one-hot.
- run_tgl inverts running. A 0→1 transition clears err_tx.
- IDLE: if running, go to TX. The counter clears on every state entry.
- TX: enTx=1.
  - overTx=1 → GUARD.
  - Otherwise, when the counter reaches TX_TIMEOUT-1 → IDLE, set err_tx, clear running.
  - overTx wins over timeout in the same cycle.
- GUARD: lasts exactly GUARD_CYC cycles, then RX. overTx and rx_done are ignored.
- RX: enRx=1.
  - rx_done=1 → rx_hit pulse.
  - Counter at RX_CYC-1 without rx_done → rx_miss pulse.
  - On either exit: burst_cnt += 1, then next state is REST if running, else IDLE.
  - rx_done wins over expiry in the same cycle.
- REST: lasts exactly REST_CYC cycles, then TX if running. If running drops, leave for IDLE on the next cycle.
- Stop during TX/GUARD/RX: the current burst completes through RX. No new TX is issued.
- rst at any cycle: state IDLE, counter 0, all outputs 0 (running=0, err_tx=0, burst_cnt=0) on the next edge. Mid-burst enTx/enRx drop immediately.

## Timing
- All outputs are flops updated on the same edge as the state. enTx/enRx/busy are exactly coincident with the state.
- Start-up: run_tgl high at edge k → running=1 after edge k → TX and enTx=1 after edge k+1.
- TX exit: overTx high at edge k → enTx=0 after edge k. GUARD is entered at k, so enRx rises GUARD_CYC cycles later.
- enRx is high for at most RX_CYC cycles. rx_hit/rx_miss assert in the cycle enRx falls.
- Burst period with immediate overTx: 1 + GUARD_CYC + RX_CYC + REST_CYC cycles, TX rise to TX rise.
- run_tgl and rst together: rst wins.

## Structure
- Package detect_pkg holds:
  - state encoding localparams
  - default cycle parameters
  - the burst_cnt width constant
- Sub-module phase_timer: CNT_W counter with synchronous clear-on-load and compare-to-limit expire output. The FSM loads the limit per state.

## Test plan
Parameters for all scenarios: GUARD=4, RX=10, REST=8, TX_TIMEOUT=16.
- Start, overTx 3 cycles after enTx, rx_done 5 cycles into RX → enTx high 3 cycles, enRx low exactly 4, rx_hit pulse, burst_cnt=1, REST 8 cycles, then enTx again.
- No rx_done → enRx high 10 cycles, one rx_miss pulse, burst_cnt increments.
- overTx never asserted → enTx high 16 cycles, err_tx=1, running=0, IDLE. Next run_tgl clears err_tx.
- run_tgl during GUARD → RX completes, burst_cnt increments, returns to IDLE, no further enTx.
- rst asserted mid-RX → next cycle all outputs 0. No rx_hit/miss is emitted.
- rx_done on the final RX cycle → rx_hit only, no rx_miss. overTx held high during GUARD/RX has no effect.

Source files
------------

// File: rtl/detect_pkg.sv
// Shared constants for the detection burst sequencer: state encoding,
// default phase lengths and the burst counter width.
package detect_pkg;

  // One-hot state encoding; bit positions are used directly as output enables.
  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_TX    = 5'b00010;
  localparam logic [4:0] ST_GUARD = 5'b00100;
  localparam logic [4:0] ST_RX    = 5'b01000;
  localparam logic [4:0] ST_REST  = 5'b10000;

  localparam int IDX_IDLE = 0;
  localparam int IDX_TX   = 1;
  localparam int IDX_RX   = 3;

  localparam int DEF_GUARD_CYC  = 1000;
  localparam int DEF_RX_CYC     = 200000;
  localparam int DEF_REST_CYC   = 1000000;
  localparam int DEF_TX_TIMEOUT = 100000;
  localparam int DEF_CNT_W      = 24;

  localparam int BURST_W = 16;

endpackage

// File: rtl/phase_timer.sv
// Phase counter: clears on load, otherwise counts up; expire flags the
// cycle in which the count equals the limit.
module phase_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || load) cnt_q <= '0;
    else             cnt_q <= cnt_q + CNT_W'(1);
  end

  assign expire = (cnt_q == limit);

endmodule

// File: rtl/detect_sequencer.sv
// Burst sequencer: TX -> blanking -> RX window -> rest, repeating while running.
//
// state | meaning
// IDLE  | stopped, waiting for running
// TX    | transmitter enabled, waiting for overTx or timeout
// GUARD | blanking between TX and RX
// RX    | receive window open, waiting for rx_done or expiry
// REST  | idle gap before the next burst
module detect_sequencer
  import detect_pkg::*;
#(
  parameter int GUARD_CYC  = DEF_GUARD_CYC,
  parameter int RX_CYC     = DEF_RX_CYC,
  parameter int REST_CYC   = DEF_REST_CYC,
  parameter int TX_TIMEOUT = DEF_TX_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clk_100,
  input  logic               rst,
  input  logic               run_tgl,
  input  logic               overTx,
  input  logic               rx_done,
  output logic               enTx,
  output logic               enRx,
  output logic               busy,
  output logic               running,
  output logic               rx_hit,
  output logic               rx_miss,
  output logic               err_tx,
  output logic [BURST_W-1:0] burst_cnt
);

  localparam logic [CNT_W-1:0] LIM_TX    = CNT_W'(TX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIM_GUARD = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_RX    = CNT_W'(RX_CYC - 1);
  localparam logic [CNT_W-1:0] LIM_REST  = CNT_W'(REST_CYC - 1);

  logic [4:0]         state_q, state_d;
  logic               running_q, running_d;
  logic               err_q, err_d;
  logic               hit_q, miss_q;
  logic [BURST_W-1:0] burst_q;
  logic               tx_timeout, rx_exit;
  logic               timer_load, timer_expire;
  logic [CNT_W-1:0]   timer_limit;

  assign timer_load = (state_d != state_q);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk_100),
    .rst    (rst),
    .load   (timer_load),
    .limit  (timer_limit),
    .expire (timer_expire)
  );

  always_comb begin
    timer_limit = '0;
    case (state_q)
      ST_TX:    timer_limit = LIM_TX;
      ST_GUARD: timer_limit = LIM_GUARD;
      ST_RX:    timer_limit = LIM_RX;
      ST_REST:  timer_limit = LIM_REST;
      default:  timer_limit = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tx_timeout = 1'b0;
    rx_exit    = 1'b0;
    case (state_q)
      ST_IDLE: if (running_q) state_d = ST_TX;
      ST_TX: begin
        if (overTx) begin
          state_d = ST_GUARD;
        end else if (timer_expire) begin
          state_d    = ST_IDLE;
          tx_timeout = 1'b1;
        end
      end
      ST_GUARD: if (timer_expire) state_d = ST_RX;
      ST_RX: begin
        if (rx_done || timer_expire) begin
          rx_exit = 1'b1;
          state_d = running_q ? ST_REST : ST_IDLE;
        end
      end
      ST_REST: begin
        // A stop ends the rest gap immediately rather than waiting it out.
        if (!running_q)        state_d = ST_IDLE;
        else if (timer_expire) state_d = ST_TX;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running_d = running_q;
    err_d     = err_q;
    if (tx_timeout) begin
      running_d = 1'b0;
      err_d     = 1'b1;
    end else if (run_tgl) begin
      running_d = ~running_q;
      if (!running_q) err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      err_q     <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      err_q     <= err_d;
      hit_q     <= rx_exit && rx_done;
      miss_q    <= rx_exit && !rx_done;
      if (rx_exit) burst_q <= burst_q + BURST_W'(1);
    end
  end

  assign enTx      = state_q[IDX_TX];
  assign enRx      = state_q[IDX_RX];
  assign busy      = ~state_q[IDX_IDLE];
  assign running   = running_q;
  assign rx_hit    = hit_q;
  assign rx_miss   = miss_q;
  assign err_tx    = err_q;
  assign burst_cnt = burst_q;

endmodule
